// File: rtl/stream_fifo_pkt_if.sv
// Stream bus bundle (tdata/tvalid/tlast/tready) shared by both sides of stream_fifo_pkt.
// A beat transfers on a rising edge where tvalid and tready are both 1; a master holds tdata/tlast stable while tvalid is high and tready is low.
interface stream_fifo_pkt_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/stream_fifo_pkt.sv
// First-word-fall-through stream FIFO with occupancy reporting.
// Define STREAM_FIFO_PKT_MODE_EN to hold output until a whole packet (tlast) is buffered.
module stream_fifo_pkt #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_fifo_pkt_if.slave         s,
    stream_fifo_pkt_if.master        m,
    output logic [AW:0]              count,
    output logic                     full,
    output logic                     empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

    // Each entry is {tdata, tlast}.
    logic [DW:0]   mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW:0]   head;
    logic          push;
    logic          pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    // Ready comes from registered occupancy only, so a full FIFO refuses a push even when a pop is pending.
    assign s.tready = ~full;
    assign push     = s.tvalid & ~full;
    assign pop      = m.tvalid & m.tready;

    assign head     = mem[rd_ptr];
    assign m.tdata  = head[DW:1];
    assign m.tlast  = head[0] & m.tvalid;

`ifdef STREAM_FIFO_PKT_MODE_EN
    logic [AW:0] pkt_cnt;

    // Once full, an oversized packet must stream out or it could never complete.
    assign m.tvalid = ~empty & ((pkt_cnt != '0) | full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            case ({push & s.tlast, pop & m.tlast})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end
`else
    assign m.tvalid = ~empty;
`endif

    // Storage is deliberately left out of reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s.tdata, s.tlast};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_fifo_pkt.sv
// Bench for stream_fifo_pkt: directed drivers feed a scoreboard queue, a forked monitor pops and compares.
// Build with STREAM_FIFO_PKT_MODE_EN defined to also exercise packet mode.
module tb_stream_fifo_pkt;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst_n;
    logic [AW:0] count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];

    stream_fifo_pkt_if #(.DW(DW)) s_if ();
    stream_fifo_pkt_if #(.DW(DW)) m_if ();

    stream_fifo_pkt #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_if),
        .m     (m_if),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Driver: present one beat and hold it until accepted, then record the expected output.
    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_if.tready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) exp_q.push_back({d, l});
        else timeout("send_accept");
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
        @(posedge clk);
        @(negedge clk);
        check({name, "_empty"}, 32'(empty), 32'd1);
        check({name, "_count"}, 32'(count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW:0] got;
        logic [DW:0] exp;
        logic [DW:0] prev_beat;
        logic        prev_stall;
        int          pkt_len[3];
        int          beat_no;

        rst_n       = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        prev_stall  = 1'b0;
        prev_beat   = '0;

        // Monitor: pops the scoreboard on every output transfer and checks stall stability.
        fork
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    if (prev_stall) begin
                        check("stall_valid", 32'(m_if.tvalid), 32'd1);
                        check("stall_stable", 32'({m_if.tdata, m_if.tlast}), 32'(prev_beat));
                    end
                    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                        got = {m_if.tdata, m_if.tlast};
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat actual=%0h required=none", got);
                        end else begin
                            exp = exp_q.pop_front();
                            check("beat", 32'(got), 32'(exp));
                        end
                    end
                    prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
                    prev_beat  = {m_if.tdata, m_if.tlast};
                end else begin
                    prev_stall = 1'b0;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_s_tready", 32'(s_if.tready), 32'd1);
        check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // T2: fill to full, refuse a 17th beat, then drain in order
        m_if.tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_beat(DW'(i), (i == DEPTH - 1));
        @(negedge clk);
        check("t2_full", 32'(full), 32'd1);
        check("t2_s_tready", 32'(s_if.tready), 32'd0);
        check("t2_count", 32'(count), 32'd16);
        @(posedge clk);
        #1;
        s_if.tdata  = 8'hAA;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        idle(2);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        check("t2_count_after_17th", 32'(count), 32'd16);
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        wait_drain("t2_drain");

        // T1: asynchronous reset mid-burst with five words stored
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(DW'(8'h50 + i), 1'b0);
        @(negedge clk);
        check("t1_count_pre", 32'(count), 32'd5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t1_count", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("t1_s_tready", 32'(s_if.tready), 32'd1);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        m_if.tready = 1'b1;
        idle(5);
        check("t1_post_count", 32'(count), 32'd0);
        check("t1_post_m_tvalid", 32'(m_if.tvalid), 32'd0);

        // T3: simultaneous push and pop holds count at 3 across pointer wrap
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(DW'(8'h30 + i), 1'b1);
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_if.tdata = DW'(8'h40 + i);
            @(negedge clk);
            check("t3_count", 32'(count), 32'd3);
            check("t3_s_tready", 32'(s_if.tready), 32'd1);
            exp_q.push_back({DW'(8'h40 + i), 1'b1});
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        wait_drain("t3_drain");

        // T5: packets of 1, 3 and 7 beats; tlast on beats 1, 4 and 11
        pkt_len[0] = 1;
        pkt_len[1] = 3;
        pkt_len[2] = 7;
        beat_no = 0;
        m_if.tready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < pkt_len[p]; b++) begin
                beat_no++;
                send_beat(DW'(8'h80 + beat_no), (b == pkt_len[p] - 1));
            end
        end
        wait_drain("t5_drain");

`ifdef STREAM_FIFO_PKT_MODE_EN
        // T6: output held until a packet completes
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(DW'(8'hC0 + i), 1'b0);
        @(negedge clk);
        check("t6_hold_m_tvalid", 32'(m_if.tvalid), 32'd0);
        @(posedge clk);
        #1;
        send_beat(8'hC3, 1'b1);
        @(negedge clk);
        check("t6_release_m_tvalid", 32'(m_if.tvalid), 32'd1);
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        wait_drain("t6_drain");

        // T6: 20-beat packet escapes once the FIFO is full
        for (int i = 0; i < 20; i++) begin
            send_beat(DW'(8'hD0 + i), (i == 19));
            if (i == 14) check("t6_long_hold", 32'(m_if.tvalid), 32'd0);
        end
        wait_drain("t6_long_drain");
`endif

        // T4: random valid/ready at 50%, 1000 beats
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 0) idle(1);
                    send_beat(DW'(i * 7 + 3), (i == 999) || ($urandom_range(0, 7) == 0));
                end
            end
            begin
                for (int c = 0; c < 6000 && !(exp_q.size() == 0 && empty === 1'b1 && c > 4000); c++) begin
                    m_if.tready = ($urandom_range(0, 1) == 1);
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_if.tready = 1'b1;
        wait_drain("t4_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
